// File: rtl/acumulador_pkg.sv
// Shared definitions for the adder-result accumulator: FSM encoding and input width.
package acumulador_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t ST_IDLE = 2'd0;
    localparam estado_t ST_ACUM = 2'd1;
    localparam estado_t ST_DONE = 2'd2;

    localparam int SUM_WIDTH = 5;

endpackage

// File: rtl/contador_sumas.sv
// Counts adder results accepted in the current burst; flags the enable that reaches N_SUMAS.
module contador_sumas #(
    parameter int N_SUMAS   = 4,
    parameter int CNT_WIDTH = $clog2(N_SUMAS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 en,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 terminal
);

    localparam logic [CNT_WIDTH-1:0] ULTIMO = CNT_WIDTH'(N_SUMAS - 1);

    // High on the enable cycle whose increment lands count on N_SUMAS.
    assign terminal = en && (count == ULTIMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/acumulador_sumador.sv
// Accumulates a burst of N_SUMAS 5-bit adder results and hands the total out on a valid/ready port.
module acumulador_sumador
    import acumulador_pkg::*;
#(
    parameter  int N_SUMAS   = 4,
    parameter  int ACC_WIDTH = 8,
    localparam int CNT_WIDTH = $clog2(N_SUMAS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4:0]           sum,
    input  logic                 sum_valid,
    output logic                 sum_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

    // Unsigned add with the carry out of ACC_WIDTH kept in the top bit.
    function automatic logic [ACC_WIDTH:0] suma_con_acarreo(
        input logic [ACC_WIDTH-1:0] a,
        input logic [SUM_WIDTH-1:0] s
    );
        return {1'b0, a} + (ACC_WIDTH + 1)'(s);
    endfunction

    estado_t             state_q;
    estado_t             state_d;
    logic                clr;
    logic                transfer;
    logic                terminal;
    logic [ACC_WIDTH:0]  suma;

    assign clr      = (state_q == ST_IDLE) && start;
    assign transfer = sum_valid && sum_ready;
    assign suma     = suma_con_acarreo(acc_out, sum);

    contador_sumas #(
        .N_SUMAS   (N_SUMAS),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_contador (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .en       (transfer),
        .count    (count),
        .terminal (terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_ACUM;
            ST_ACUM: if (terminal)  state_d = ST_DONE;
            ST_DONE: if (acc_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs depend on state only, so sum_ready never waits on sum_valid.
    always_comb begin
        sum_ready = 1'b0;
        acc_valid = 1'b0;
        case (state_q)
            ST_ACUM: sum_ready = 1'b1;
            ST_DONE: acc_valid = 1'b1;
            default: ;
        endcase
    end

    // sum is only looked at on transfer cycles; the total and flag hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            acc_out  <= '0;
            overflow <= 1'b0;
        end else if (transfer) begin
            acc_out  <= suma[ACC_WIDTH-1:0];
            overflow <= overflow | suma[ACC_WIDTH];
        end
    end

endmodule

// File: tb/tb_acumulador_sumador.sv
// Bench for acumulador_sumador: table of bursts with a result scoreboard, plus corner sequences.
module tb_acumulador_sumador;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Default instance
    logic       start = 0, sum_valid = 0, acc_ready = 0;
    logic [4:0] sum = 0;
    logic       sum_ready, acc_valid, overflow;
    logic [7:0] acc_out;
    logic [2:0] count;

    acumulador_sumador u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sum(sum), .sum_valid(sum_valid),
        .sum_ready(sum_ready), .acc_out(acc_out), .acc_valid(acc_valid),
        .acc_ready(acc_ready), .overflow(overflow), .count(count)
    );

    // Narrow accumulator instance
    logic       start6 = 0, sum_valid6 = 0, acc_ready6 = 0;
    logic [4:0] sum6 = 0;
    logic       sum_ready6, acc_valid6, overflow6;
    logic [5:0] acc_out6;
    logic [2:0] count6;

    acumulador_sumador #(.N_SUMAS(4), .ACC_WIDTH(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start6), .sum(sum6), .sum_valid(sum_valid6),
        .sum_ready(sum_ready6), .acc_out(acc_out6), .acc_valid(acc_valid6),
        .acc_ready(acc_ready6), .overflow(overflow6), .count(count6)
    );

    // Single-result burst instance
    logic       start1 = 0, sum_valid1 = 0, acc_ready1 = 0;
    logic [4:0] sum1 = 0;
    logic       sum_ready1, acc_valid1, overflow1;
    logic [7:0] acc_out1;
    logic [0:0] count1;

    acumulador_sumador #(.N_SUMAS(1), .ACC_WIDTH(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sum(sum1), .sum_valid(sum_valid1),
        .sum_ready(sum_ready1), .acc_out(acc_out1), .acc_valid(acc_valid1),
        .acc_ready(acc_ready1), .overflow(overflow1), .count(count1)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [19:0] sums;
        logic [7:0]  vpat;
        logic [7:0]  exp_acc;
        logic        exp_ovf;
        int          hold;
        bit          start_mid;
        bit          start_done;
    } vec_t;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t sb[$];

    // Scoreboard: a result is consumed on the cycle the handshake is presented.
    always @(negedge clk) begin
        if (rst_n && acc_valid && acc_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got acc_out %0d, expected no result", acc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_acc", 32'(acc_out), 32'(e.acc));
                chk("sb_ovf", 32'(overflow), 32'(e.ovf));
                chk("sb_cnt", 32'(count), 32'd4);
            end
        end
    end

    task automatic run_burst(input vec_t v);
        int  k;
        int  cyc;
        int  macc;
        bit  did_mid;
        exp_t e;
        e.acc = v.exp_acc;
        e.ovf = v.exp_ovf;
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_acc", 32'(acc_out), 32'd0);
        chk("start_cnt", 32'(count), 32'd0);
        chk("acum_ready", 32'(sum_ready), 32'd1);
        k = 0;
        cyc = 0;
        macc = 0;
        did_mid = 0;
        while (k < 4 && cyc < 16) begin
            if (v.start_mid && k == 2 && !did_mid) begin
                start = 1'b1;
                sum_valid = 1'b0;
                sum = 5'($urandom);
                tick();
                start = 1'b0;
                did_mid = 1;
                chk("mid_start_cnt", 32'(count), 32'd2);
                chk("mid_start_acc", 32'(acc_out), 32'(macc & 255));
                chk("mid_start_ready", 32'(sum_ready), 32'd1);
            end
            sum_valid = (cyc < 8) ? v.vpat[cyc] : 1'b1;
            sum = sum_valid ? v.sums[k*5 +: 5] : 5'($urandom);
            tick();
            if (sum_valid) begin
                macc += int'(v.sums[k*5 +: 5]);
                k++;
                chk("xfer_acc", 32'(acc_out), 32'(macc & 255));
                chk("xfer_cnt", 32'(count), 32'(k));
            end
            cyc++;
        end
        sum_valid = 1'b0;
        if (k < 4) chk("burst_bound", 32'(k), 32'd4);
        chk("lat_valid", 32'(acc_valid), 32'd1);
        chk("done_ready", 32'(sum_ready), 32'd0);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            chk("hold_valid", 32'(acc_valid), 32'd1);
            chk("hold_acc", 32'(acc_out), 32'(v.exp_acc));
            chk("hold_ready", 32'(sum_ready), 32'd0);
        end
        acc_ready = 1'b1;
        start = v.start_done;
        tick();
        acc_ready = 1'b0;
        start = 1'b0;
        chk("hs_valid", 32'(acc_valid), 32'd0);
        chk("hs_idle", 32'(sum_ready), 32'd0);
        chk("hs_acc", 32'(acc_out), 32'(v.exp_acc));
        if (v.start_done) begin
            tick();
            chk("no_restart_ready", 32'(sum_ready), 32'd0);
            chk("no_restart_cnt", 32'(count), 32'd4);
        end
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{sums: {5'd0, 5'd31, 5'd22, 5'd5},  vpat: 8'hFF, exp_acc: 8'd58,  exp_ovf: 1'b0, hold: 0, start_mid: 0, start_done: 0};
        vecs[1] = '{sums: {5'd6, 5'd5, 5'd4, 5'd3},    vpat: 8'h69, exp_acc: 8'd18,  exp_ovf: 1'b0, hold: 0, start_mid: 0, start_done: 0};
        vecs[2] = '{sums: {5'd0, 5'd31, 5'd22, 5'd5},  vpat: 8'hFF, exp_acc: 8'd58,  exp_ovf: 1'b0, hold: 5, start_mid: 0, start_done: 0};
        vecs[3] = '{sums: {5'd31, 5'd31, 5'd31, 5'd31}, vpat: 8'hFF, exp_acc: 8'd124, exp_ovf: 1'b0, hold: 0, start_mid: 1, start_done: 0};
        vecs[4] = '{sums: {5'd0, 5'd0, 5'd0, 5'd0},    vpat: 8'h55, exp_acc: 8'd0,   exp_ovf: 1'b0, hold: 1, start_mid: 0, start_done: 1};
        vecs[5] = '{sums: {5'd4, 5'd3, 5'd2, 5'd1},    vpat: 8'hFF, exp_acc: 8'd10,  exp_ovf: 1'b0, hold: 0, start_mid: 0, start_done: 0};

        // Reset state
        tick();
        tick();
        chk("rst_acc", 32'(acc_out), 32'd0);
        chk("rst_cnt", 32'(count), 32'd0);
        chk("rst_valid", 32'(acc_valid), 32'd0);
        chk("rst_ready", 32'(sum_ready), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(sum_ready), 32'd0);

        foreach (vecs[i]) run_burst(vecs[i]);

        // Asynchronous reset in the middle of a burst
        start = 1'b1;
        tick();
        start = 1'b0;
        sum_valid = 1'b1;
        sum = 5'd7;
        tick();
        sum = 5'd9;
        tick();
        sum_valid = 1'b0;
        chk("pre_rst_cnt", 32'(count), 32'd2);
        chk("pre_rst_acc", 32'(acc_out), 32'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_acc", 32'(acc_out), 32'd0);
        chk("async_rst_cnt", 32'(count), 32'd0);
        chk("async_rst_valid", 32'(acc_valid), 32'd0);
        chk("async_rst_ready", 32'(sum_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        sum_valid = 1'b1;
        sum = 5'd5;
        repeat (3) tick();
        sum_valid = 1'b0;
        chk("post_rst_cnt", 32'(count), 32'd0);
        chk("post_rst_acc", 32'(acc_out), 32'd0);
        chk("post_rst_ready", 32'(sum_ready), 32'd0);

        run_burst(vecs[0]);

        // ACC_WIDTH=6: carry leaves the accumulator on the third 31
        begin
            logic [5:0] e6[4];
            logic       o6[4];
            e6 = '{6'd31, 6'd62, 6'd29, 6'd60};
            o6 = '{1'b0, 1'b0, 1'b1, 1'b1};
            start6 = 1'b1;
            tick();
            start6 = 1'b0;
            sum_valid6 = 1'b1;
            sum6 = 5'd31;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("w6_acc", 32'(acc_out6), 32'(e6[i]));
                chk("w6_ovf", 32'(overflow6), 32'(o6[i]));
            end
            sum_valid6 = 1'b0;
            chk("w6_valid", 32'(acc_valid6), 32'd1);
            repeat (2) begin
                tick();
                chk("w6_hold_ovf", 32'(overflow6), 32'd1);
                chk("w6_hold_acc", 32'(acc_out6), 32'd60);
            end
            acc_ready6 = 1'b1;
            tick();
            acc_ready6 = 1'b0;
            chk("w6_hs_valid", 32'(acc_valid6), 32'd0);
            chk("w6_idle_ovf", 32'(overflow6), 32'd1);
            start6 = 1'b1;
            tick();
            start6 = 1'b0;
            chk("w6_clear_ovf", 32'(overflow6), 32'd0);
            chk("w6_clear_acc", 32'(acc_out6), 32'd0);
        end

        // N_SUMAS=1: a single transfer completes the burst
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        sum_valid1 = 1'b1;
        sum1 = 5'd17;
        tick();
        sum_valid1 = 1'b0;
        chk("n1_valid", 32'(acc_valid1), 32'd1);
        chk("n1_acc", 32'(acc_out1), 32'd17);
        chk("n1_cnt", 32'(count1), 32'd1);
        chk("n1_ovf", 32'(overflow1), 32'd0);
        acc_ready1 = 1'b1;
        tick();
        acc_ready1 = 1'b0;
        chk("n1_hs_valid", 32'(acc_valid1), 32'd0);

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
